// File: rtl/ehgu_arith_arbiter.sv
// ============================================================================
// Module   : ehgu_arith_arbiter
// Brief    : Round-robin arbiter feeding a one-deep modular/saturating
//            add/sub unit. Optional flag counter: EHGU_ARITH_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ehgu_config_pkg;
  localparam int DP_WIDTH = 8;
endpackage

module ehgu_arith_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DP_WIDTH = ehgu_config_pkg::DP_WIDTH,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic [2*NUM_REQ-1:0]         i_req_op,
  input  logic [DP_WIDTH*NUM_REQ-1:0]  i_req_a,
  input  logic [DP_WIDTH*NUM_REQ-1:0]  i_req_b,
  input  logic [DP_WIDTH:0]            i_cfg_modulo,
  input  logic [DP_WIDTH-1:0]          i_cfg_max,
  input  logic [DP_WIDTH-1:0]          i_cfg_min,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [IDW-1:0]               o_rsp_id,
  output logic [DP_WIDTH-1:0]          o_rsp_data,
  output logic                         o_rsp_flag
`ifdef EHGU_ARITH_ARB_STATS_EN
  ,
  output logic [15:0]                  o_stat_flag_cnt
`endif
);

  logic [IDW-1:0]      r_ptr;
  logic                r_valid;
  logic [IDW-1:0]      r_id;
  logic [DP_WIDTH-1:0] r_data;
  logic                r_flag;

  logic                w_found;
  logic [IDW-1:0]      w_gnt;
  logic                w_free;
  logic                w_xfer;
  logic [1:0]          w_op;
  logic [DP_WIDTH-1:0] w_a;
  logic [DP_WIDTH-1:0] w_b;
  logic [DP_WIDTH:0]   w_sum;
  logic [DP_WIDTH:0]   w_bmin;
  logic [DP_WIDTH+1:0] w_wrap;
  logic [DP_WIDTH-1:0] w_res;
  logic                w_flag;

  // First valid requester at or after r_ptr, wrapping upward.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    v_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found) begin
        v_idx = int'(r_ptr) + i;
        if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
        if (i_req_valid[v_idx]) begin
          w_found = 1'b1;
          w_gnt   = IDW'(v_idx);
        end
      end
    end
  end

  // Gating with rst_n keeps ready low for the whole asynchronous reset window.
  assign w_free = rst_n & (~r_valid | i_rsp_ready);
  assign w_xfer = w_found & w_free;

  always_comb begin
    o_req_ready = '0;
    if (w_xfer) o_req_ready[w_gnt] = 1'b1;
  end

  assign w_op = i_req_op[int'(w_gnt)*2 +: 2];
  assign w_a  = i_req_a[int'(w_gnt)*DP_WIDTH +: DP_WIDTH];
  assign w_b  = i_req_b[int'(w_gnt)*DP_WIDTH +: DP_WIDTH];

  always_comb begin
    w_sum  = {1'b0, w_a} + {1'b0, w_b};
    w_bmin = {1'b0, w_b} + {1'b0, i_cfg_min};
    w_wrap = {2'b00, w_a} + {1'b0, i_cfg_modulo} - {2'b00, w_b};
    w_res  = '0;
    w_flag = 1'b0;
    case (w_op)
      2'b00: begin
        if (w_sum >= i_cfg_modulo) begin
          w_res  = DP_WIDTH'(w_sum - i_cfg_modulo);
          w_flag = 1'b1;
        end else begin
          w_res  = w_sum[DP_WIDTH-1:0];
        end
      end
      2'b01: begin
        if (w_sum > {1'b0, i_cfg_max}) begin
          w_res  = i_cfg_max;
          w_flag = 1'b1;
        end else begin
          w_res  = w_sum[DP_WIDTH-1:0];
        end
      end
      2'b10: begin
        if (w_a < w_b) begin
          w_res  = w_wrap[DP_WIDTH-1:0];
          w_flag = 1'b1;
        end else begin
          w_res  = w_a - w_b;
        end
      end
      default: begin
        if ({1'b0, w_a} < w_bmin) begin
          w_res  = i_cfg_min;
          w_flag = 1'b1;
        end else begin
          w_res  = w_a - w_b;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
      r_flag  <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_id    <= w_gnt;
      r_data  <= w_res;
      r_flag  <= w_flag;
      r_ptr   <= (w_gnt == IDW'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
    end else if (i_rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_valid;
  assign o_rsp_id    = r_id;
  assign o_rsp_data  = r_data;
  assign o_rsp_flag  = r_flag;

`ifdef EHGU_ARITH_ARB_STATS_EN
  logic [15:0] r_flag_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_cnt <= '0;
    end else if (w_xfer && w_flag && (r_flag_cnt != 16'hFFFF)) begin
      r_flag_cnt <= r_flag_cnt + 16'd1;
    end
  end

  assign o_stat_flag_cnt = r_flag_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ehgu_arith_arbiter.sv
// ============================================================================
// Module   : tb_ehgu_arith_arbiter
// Brief    : Directed and random checks of ehgu_arith_arbiter against a
//            behavioural model (NUM_REQ=4, DP_WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ehgu_arith_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [7:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [8:0]  cmod;
  logic [7:0]  cmax;
  logic [7:0]  cmin;
  logic        rsp_ready;

  logic [3:0]  o_req_ready;
  logic        o_rsp_valid;
  logic [1:0]  o_rsp_id;
  logic [7:0]  o_rsp_data;
  logic        o_rsp_flag;
`ifdef EHGU_ARITH_ARB_STATS_EN
  logic [15:0] o_stat_flag_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: a one-entry result holder and the rotating priority.
  int m_ptr;
  bit m_valid;
  int m_id;
  int m_data;
  int m_flag;
  int m_cnt;

  ehgu_arith_arbiter #(.NUM_REQ(4), .DP_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (valid),
    .o_req_ready  (o_req_ready),
    .i_req_op     (op),
    .i_req_a      (opa),
    .i_req_b      (opb),
    .i_cfg_modulo (cmod),
    .i_cfg_max    (cmax),
    .i_cfg_min    (cmin),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_flag   (o_rsp_flag)
`ifdef EHGU_ARITH_ARB_STATS_EN
    ,
    .o_stat_flag_cnt (o_stat_flag_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_op(input int code, input int a, input int b,
                                 output int d, output int f);
    int s;
    s = a + b;
    d = 0;
    f = 0;
    case (code)
      0: if (s >= int'(cmod)) begin d = (s - int'(cmod)) & 255; f = 1; end else d = s;
      1: if (s > int'(cmax)) begin d = int'(cmax); f = 1; end else d = s;
      2: if (a < b) begin d = (a + int'(cmod) - b) & 255; f = 1; end else d = a - b;
      default: if (a < b + int'(cmin)) begin d = int'(cmin); f = 1; end else d = a - b;
    endcase
  endfunction

  task automatic rand_inputs();
    valid     = 4'($urandom);
    op        = 8'($urandom);
    opa       = $urandom;
    opb       = $urandom;
    cmod      = 9'($urandom_range(256, 1));
    cmax      = 8'($urandom);
    cmin      = 8'($urandom);
    rsp_ready = ($urandom % 4) != 0;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 0;
    m_id    = 0;
    m_data  = 0;
    m_flag  = 0;
    m_cnt   = 0;
  endtask

  // Checks outputs against the model at the falling edge, then advances the
  // model across the rising edge; returns 1ns after that edge.
  task automatic tick();
    bit found;
    bit free;
    int g;
    int er;
    int d;
    int f;
    @(negedge clk);
    found = 0;
    g     = 0;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (m_ptr + i) % 4;
      if (!found && valid[k]) begin
        found = 1;
        g     = k;
      end
    end
    free = !m_valid || rsp_ready;
    er   = (found && free) ? (1 << g) : 0;
    check("req_ready", o_req_ready, er);
    check("rsp_valid", o_rsp_valid, m_valid);
    if (m_valid) begin
      check("rsp_id", o_rsp_id, m_id);
      check("rsp_data", o_rsp_data, m_data);
      check("rsp_flag", o_rsp_flag, m_flag);
    end
`ifdef EHGU_ARITH_ARB_STATS_EN
    check("stat_cnt", o_stat_flag_cnt, m_cnt);
`endif
    @(posedge clk);
    if (found && free) begin
      ref_op(op[2*g +: 2], opa[8*g +: 8], opb[8*g +: 8], d, f);
      m_valid = 1;
      m_id    = g;
      m_data  = d;
      m_flag  = f;
      m_ptr   = (g + 1) % 4;
      if (f != 0 && m_cnt < 65535) m_cnt++;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rand_inputs();
    valid = 4'hF;
    rst_n = 1'b0;
    #1;
    check("rst_valid", o_rsp_valid, 0);
    check("rst_id", o_rsp_id, 0);
    check("rst_data", o_rsp_data, 0);
    check("rst_flag", o_rsp_flag, 0);
    check("rst_ready", o_req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_ready_hold", o_req_ready, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [1:0] s_id;
    logic [7:0] s_data;
    logic       s_flag;
    int         seq [6];

    seq   = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b1;
    rand_inputs();
    model_reset();
    do_reset();

    // Requester 2 add_mod wrap.
    valid = 4'b0100; op = 8'h00; rsp_ready = 1'b1; cmod = 9'd256;
    opa = 32'h00C8_0000; opb = 32'h0064_0000;
    tick();
    check("am_valid", o_rsp_valid, 1);
    check("am_id", o_rsp_id, 2);
    check("am_data", o_rsp_data, 44);
    check("am_flag", o_rsp_flag, 1);
    valid = 4'b0000;
    tick();

    // Full contention: strict rotation, one result per cycle.
    do_reset();
    valid = 4'hF; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = 8'($urandom); opa = $urandom; opb = $urandom;
      tick();
      check("rr_valid", o_rsp_valid, 1);
      check("rr_id", o_rsp_id, seq[i]);
    end

    // Backpressure: held result must not move even as operands change.
    rsp_ready = 1'b0;
    s_id = o_rsp_id; s_data = o_rsp_data; s_flag = o_rsp_flag;
    for (int i = 0; i < 3; i++) begin
      opa = $urandom; opb = $urandom; op = 8'($urandom);
      tick();
      check("bp_ready", o_req_ready, 0);
      check("bp_id", o_rsp_id, s_id);
      check("bp_data", o_rsp_data, s_data);
      check("bp_flag", o_rsp_flag, s_flag);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_next_valid", o_rsp_valid, 1);
    check("bp_next_id", o_rsp_id, (s_id + 2'd1));

    // Saturating corner cases.
    do_reset();
    valid = 4'b0001; rsp_ready = 1'b1; cmin = 8'd0; cmax = 8'd250; cmod = 9'd256;
    op = 8'h03; opa = 32'd5; opb = 32'd10;
    tick();
    check("ss_lo_data", o_rsp_data, 0);
    check("ss_lo_flag", o_rsp_flag, 1);
    opa = 32'd10; opb = 32'd10;
    tick();
    check("ss_eq_data", o_rsp_data, 0);
    check("ss_eq_flag", o_rsp_flag, 0);
    op = 8'h01; opa = 32'd200; opb = 32'd60;
    tick();
    check("as_data", o_rsp_data, 250);
    check("as_flag", o_rsp_flag, 1);

    // Reset pulse discards a held result; search restarts at requester 0.
    rsp_ready = 1'b0;
    tick();
    check("rp_held", o_rsp_valid, 1);
    valid = 4'b0000;
    rst_n = 1'b0;
    #2;
    check("rp_valid_low", o_rsp_valid, 0);
    rst_n = 1'b1;
    model_reset();
    tick();
    valid = 4'b1000;
    tick();
    check("rp_id", o_rsp_id, 3);
    check("rp_valid", o_rsp_valid, 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299, 0) == 0) do_reset();
      rand_inputs();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ehgu_arith_arbiter.md
EHGU_ARITH_ARBITER -- requirements
Module: ehgu_arith_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..16).
REQ-002 Parameter DP_WIDTH, default ehgu_config_pkg::DP_WIDTH, SHALL set the operand and result width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  in  NUM_REQ  SHALL flag a pending request per requester.
REQ-006 req_ready  out  NUM_REQ  SHALL flag request acceptance; at most one bit high per cycle.
REQ-007 req_op  in  2*NUM_REQ  SHALL carry the per-requester opcode: 00 add_mod, 01 add_sat, 10 sub_mod, 11 sub_sat.
REQ-008 req_a, req_b  in  DP_WIDTH*NUM_REQ each  SHALL carry the per-requester unsigned operands.
REQ-009 cfg_modulo  in  DP_WIDTH+1  SHALL be the modulo for _mod ops; 0 is illegal.
REQ-010 cfg_max, cfg_min  in  DP_WIDTH each  SHALL be the saturation bounds for add_sat and sub_sat.
REQ-011 rsp_valid  out  1  SHALL flag a held result; rsp_ready  in  1  SHALL flag consumer acceptance.
REQ-012 rsp_id  out  $clog2(NUM_REQ)  SHALL give the index of the requester owning the result.
REQ-013 rsp_data  out  DP_WIDTH  SHALL give the result; rsp_flag  out  1  SHALL flag wrap or saturation.

Function
REQ-014 Grant SHALL be round-robin: first valid requester at or after the priority pointer ptr, searching upward with wrap.
REQ-015 The response slot SHALL be free when rsp_valid=0 or rsp_ready=1.
REQ-016 req_ready[g] SHALL be 1 only for the granted index g and only while the slot is free; a transfer occurs when req_valid[g]&req_ready[g].
REQ-017 On a transfer, ptr SHALL become (g+1) mod NUM_REQ; without a transfer, ptr SHALL hold.
REQ-018 Latency SHALL be one cycle: a transfer in cycle N produces rsp_valid=1 with result and id in cycle N+1.
REQ-019 Throughput SHALL be one result per cycle: a drain (rsp_valid&rsp_ready) and a new transfer SHALL occur in the same cycle.
REQ-020 With rsp_valid=1 and rsp_ready=0, rsp_id, rsp_data and rsp_flag SHALL hold stable.
REQ-021 rsp_valid SHALL clear after a drain with no simultaneous transfer.
REQ-022 add_mod: s=a+b at DP_WIDTH+1 bits; if s>=cfg_modulo then data=s-cfg_modulo and flag=1, else data=s and flag=0.
REQ-023 add_sat: s=a+b at DP_WIDTH+1 bits; if s>cfg_max then data=cfg_max and flag=1, else data=s and flag=0.
REQ-024 sub_mod: if a<b then data=a+cfg_modulo-b and flag=1, else data=a-b and flag=0.
REQ-025 sub_sat: if a<b+cfg_min (DP_WIDTH+1 bits) then data=cfg_min and flag=1, else data=a-b and flag=0.
REQ-026 Operands SHALL be sampled only at the transfer cycle; later operand changes SHALL not alter a held result.
REQ-027 Dropping req_valid without a transfer SHALL be allowed and SHALL not move ptr.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flag=0, ptr=0 and the stats counter to 0.
REQ-029 While rst_n=0, req_ready SHALL be all 0.
REQ-030 A result held when reset asserts SHALL be discarded and SHALL not reappear after release.
REQ-031 The first grant after release SHALL start the search at requester 0.

Configuration
REQ-032 With EHGU_ARITH_ARB_STATS_EN defined, output stat_flag_cnt (16 bits) SHALL count transfers that set rsp_flag, saturating at 16'hFFFF.
REQ-033 stat_flag_cnt SHALL update in the cycle the flagged result is loaded into the response register.
REQ-034 Without EHGU_ARITH_ARB_STATS_EN, port stat_flag_cnt and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (NUM_REQ=4, DP_WIDTH=8)
REQ-035 Reset: hold rst_n=0 with all inputs random -> all outputs 0 and req_ready=4'b0000.
REQ-036 Requester 2, add_mod, a=200, b=100, cfg_modulo=256; transfer in cycle N -> cycle N+1: rsp_valid=1, rsp_id=2, rsp_data=44, rsp_flag=1.
REQ-037 req_valid=4'b1111 held with rsp_ready=1 -> grant order 0,1,2,3,0,1 with one rsp_valid per cycle.
REQ-038 rsp_ready=0 for 3 cycles while rsp_valid=1 -> req_ready=0 and outputs stable; then rsp_ready=1 -> drain and next transfer in the same cycle.
REQ-039 sub_sat, cfg_min=0: a=5, b=10 -> data=0, flag=1; a=10, b=10 -> data=0, flag=0; add_sat with cfg_max=250, a=200, b=60 -> data=250, flag=1.
REQ-040 rst_n pulsed low while rsp_valid=1 with rsp_ready=0 -> rsp_valid=0 during the pulse; after release, req_valid=4'b1000 -> rsp_id=3.
